// File: rtl/alu_pkg.sv
// Shared types and constants for the registered 8-bit ALU.
// Opcode encoding plus the divide-by-zero quotient value.
// No state lives here.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3
    } alu_op_e;

    // Quotient reported when the divisor is zero: saturate to all-ones.
    localparam logic [ALU_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/alu_interface.sv
// Signal bundle connecting a bench or a parent block to alu_8b.
// Latency: none, wires only.
// Backpressure: none, one operation is accepted per cycle.
interface alu_interface #(
    parameter int WIDTH = 8
) (
    input logic clk
);
    logic             rst_n;
    logic [2:0]       ctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic             cout;

    modport dut (input clk, input rst_n, input ctl, input a, input b, output q, output cout);
    modport drv (input clk, output rst_n, output ctl, output a, output b, input q, input cout);
endinterface

// File: rtl/alu_8b_comb.sv
// Purely combinational result generator: add, subtract, multiply, restoring divide.
// Latency: zero, res follows ctl/a/b combinationally.
// Backpressure: none, evaluated continuously.
module alu_8b_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   res
);

    // Quotient forced out when b is zero.
    localparam logic [WIDTH-1:0] DivZeroQuot = '1;

    alu_op_e          op;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH:0]   add_res;
    logic [WIDTH:0]   sub_res;
    logic [WIDTH:0]   mul_res;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_res;
    logic             b_zero;

    assign op     = alu_op_e'(ctl);
    assign a_ext  = {1'b0, a};
    assign b_ext  = {1'b0, b};
    assign b_zero = (b == '0);

    // Add keeps the carry in the top bit; subtract wraps modulo 2^(WIDTH+1),
    // so the top bit is set exactly when a < b (borrow).
    assign add_res = a_ext + b_ext;
    assign sub_res = a_ext - b_ext;

    // Product evaluated at WIDTH+1 bits: higher product bits are intentionally dropped.
    assign mul_res = a_ext * b_ext;

    // Unrolled restoring divider: one shift/compare/subtract step per quotient bit, MSB first.
    always_comb begin
        logic [WIDTH:0] rem;
        rem      = '0;
        div_quot = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            rem = {rem[WIDTH-1:0], a[i]};
            if (rem >= b_ext) begin
                rem         = rem - b_ext;
                div_quot[i] = 1'b1;
            end
        end
    end

    // Divide by zero gets an explicit value so the result never depends on divider internals.
    assign div_res = b_zero ? DivZeroQuot : div_quot;

    // Opcode select; the unused encodings fall back to addition.
    always_comb begin
        res = add_res;
        case (op)
            OP_ADD:  res = add_res;
            OP_SUB:  res = sub_res;
            OP_MUL:  res = mul_res;
            OP_DIV:  res = {1'b0, div_res};
            default: res = add_res;
        endcase
    end

endmodule

// File: rtl/alu_8b.sv
// Registered 8-bit ALU: combinational result captured into q/cout each clock.
// Latency: 1 cycle from operands sampled at an edge to q/cout after that edge.
// Backpressure: none, a new operation is accepted every cycle.
module alu_8b
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] q,
    output logic             cout
);

    logic [WIDTH:0]   res;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;
    logic             cout_d;
    logic             cout_q;

    alu_8b_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .ctl (ctl),
        .a   (a),
        .b   (b),
        .res (res)
    );

    assign q_d    = res[WIDTH-1:0];
    assign cout_d = res[WIDTH];

    // Output register; reset clears immediately and discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cout_q <= cout_d;
        end
    end

    assign q    = q_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_alu_8b.sv
// Self-checking bench for alu_8b: directed corner cases, a back-to-back stream
// with a mid-stream reset, and randomized operations against an arithmetic model.
`timescale 1ns/1ps
module tb_alu_8b;

    logic clk;
    int   err_cnt;
    int   chk_cnt;

    alu_interface #(.WIDTH(8)) bus (.clk(clk));

    alu_8b #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (bus.rst_n),
        .ctl   (bus.ctl),
        .a     (bus.a),
        .b     (bus.b),
        .q     (bus.q),
        .cout  (bus.cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: result as a 9-bit integer, computed with plain arithmetic.
    function automatic int ref_res(input int op, input int av, input int bv);
        int r;
        case (op)
            1:       r = (av - bv + 512) % 512;
            2:       r = (av * bv) % 512;
            3:       r = (bv == 0) ? 255 : (av / bv);
            default: r = av + bv;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int exp_res);
        chk({tag, ".q"},    int'(bus.q),    exp_res % 256);
        chk({tag, ".cout"}, int'(bus.cout), exp_res / 256);
    endtask

    // Drive one operation at the falling edge, check it just after the next rising edge.
    task automatic do_op(input string tag, input int op, input int av, input int bv);
        @(negedge clk);
        bus.ctl = 3'(op);
        bus.a   = 8'(av);
        bus.b   = 8'(bv);
        @(posedge clk);
        #1;
        check_out(tag, ref_res(op, av, bv));
    endtask

    typedef struct {
        int op;
        int av;
        int bv;
    } vec_t;

    vec_t dir[$];
    int   exp_q[$];

    initial begin
        err_cnt   = 0;
        chk_cnt   = 0;
        bus.rst_n = 1'b0;
        bus.ctl   = 3'd0;
        bus.a     = 8'd5;
        bus.b     = 8'd3;

        // Reset held with the clock running: outputs stay zero.
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_hold", 0);

        // First edge after release loads 5+3.
        @(negedge clk);
        bus.rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_out("reset_release", 8);

        // Directed corner cases (expected values come from ref_res).
        dir = '{
            '{0, 200, 100}, '{5, 200, 100}, '{7, 255, 1},
            '{1, 2, 2},     '{1, 3, 5},     '{1, 0, 255},
            '{2, 3, 4},     '{2, 16, 17},   '{2, 20, 30},  '{2, 255, 255},
            '{3, 100, 7},   '{3, 4, 6},     '{3, 9, 0},    '{3, 255, 1},
            '{3, 0, 0},     '{4, 1, 1},     '{6, 128, 128}
        };
        foreach (dir[k]) do_op($sformatf("dir%0d_op%0d", k, dir[k].op),
                               dir[k].op, dir[k].av, dir[k].bv);

        // Explicit literal checks of the headline cases.
        do_op("add_carry", 0, 200, 100);
        chk("add_carry_lit", {23'd0, bus.cout, bus.q}, 9'h12C);
        do_op("sub_borrow", 1, 3, 5);
        chk("sub_borrow_lit", {23'd0, bus.cout, bus.q}, 9'h1FE);
        do_op("mul_16x17", 2, 16, 17);
        chk("mul_16x17_lit", {23'd0, bus.cout, bus.q}, 9'h110);
        do_op("div_by0", 3, 9, 0);
        chk("div_by0_lit", {23'd0, bus.cout, bus.q}, 9'h0FF);

        // Back-to-back stream, one op per cycle, with an async reset in the middle.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.ctl = 3'(i % 4);
            bus.a   = 8'(i + 1);
            bus.b   = 8'(2 * i);
            exp_q.push_back(ref_res(i % 4, (i + 1) % 256, (2 * i) % 256));
            @(posedge clk);
            #1;
            check_out($sformatf("stream%0d", i), exp_q.pop_front());
            if (i == 10) begin
                // Mid-cycle assertion: outputs must clear without any clock edge.
                #1;
                bus.rst_n = 1'b0;
                #1;
                check_out("stream_async_rst", 0);
                @(posedge clk);
                #1;
                check_out("stream_rst_held", 0);
                @(negedge clk);
                bus.rst_n = 1'b1;
            end
        end

        // Randomized operations; b forced to zero now and then to cover divide-by-zero.
        for (int n = 0; n < 300; n++) begin
            int op, av, bv;
            op = int'($urandom_range(7, 0));
            av = int'($urandom_range(255, 0));
            bv = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(255, 0));
            do_op($sformatf("rnd%0d_op%0d_a%0d_b%0d", n, op, av, bv), op, av, bv);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
